csr_access_controller: RTL and testbench

//   Sequences all accesses to the CSR bus (the shared write/read-enable, address, data, request-output bus feeding every
//   CSR register). Arbitrates between the core pipeline (CSRRW/CSRRS/CSRRC) and the debug/management port, performs

---
 rtl/csr_access_pkg.sv | 62 ++++++
 rtl/csr_request_arbiter.sv | 52 +++++
 rtl/csr_access_controller.sv | 199 +++++++++++++++++++
 tb/tb_csr_access_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_pkg.sv
// Purpose : shared types and helpers for the CSR access controller and its arbiter.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: CSR op encodings, FSM state enum, requester ids, the read-only
// address pattern, and helpers for write-need, read-only test and modify data.
package csr_access_pkg;

  // Core op field encoding. 2'b00 is reserved and is rejected at accept.
  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_READ    = 2'b01,
    ST_WRITE   = 2'b10,
    ST_RESPOND = 2'b11
  } csr_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

  // CSR address space convention: address[11:10] == 2'b11 marks read-only CSRs.
  localparam logic [1:0] CSR_RO_PATTERN = 2'b11;

  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return (addr[11:10] == CSR_RO_PATTERN);
  endfunction

  // RW always writes; RS/RC write unless rs1 was x0 (no_write).
  function automatic logic csr_needs_write(input csr_op_e op, input logic no_write);
    logic w_need;
    case (op)
      CSR_OP_RW: w_need = 1'b1;
      CSR_OP_RS,
      CSR_OP_RC: w_need = ~no_write;
      default:   w_need = 1'b0;
    endcase
    return w_need;
  endfunction

  // Value written back during the write phase of the read-modify-write.
  function automatic logic [31:0] csr_modify(input csr_op_e op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
    logic [31:0] w_val;
    case (op)
      CSR_OP_RW: w_val = operand;
      CSR_OP_RS: w_val = old_val | operand;
      CSR_OP_RC: w_val = old_val & ~operand;
      default:   w_val = old_val;
    endcase
    return w_val;
  endfunction

endpackage

// File: rtl/csr_request_arbiter.sv
// Purpose : two-requester (core/debug) grant for the CSR access controller.
// Latency : combinational grant; round-robin pointer updates on the grant edge.
// Backpressure: grants only while i_en is high; a grant equals the handshake.
//
// Ports: clk/rst (sync, active-high); i_en = controller can accept;
//        i_core_vld/i_dbg_vld = request valids; o_core_gnt/o_dbg_gnt = one-hot grant.
module csr_request_arbiter
  import csr_access_pkg::*;
#(
  parameter bit DEBUG_PRIORITY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_core_vld,
  input  logic i_dbg_vld,
  output logic o_core_gnt,
  output logic o_dbg_gnt
);

  // Requester favoured on the next contested grant.
  req_id_e r_rr_ptr;

  always_comb begin
    o_core_gnt = 1'b0;
    o_dbg_gnt  = 1'b0;
    if (i_en) begin
      if (i_core_vld && i_dbg_vld) begin
        if (DEBUG_PRIORITY || (r_rr_ptr == REQ_DBG)) begin
          o_dbg_gnt = 1'b1;
        end else begin
          o_core_gnt = 1'b1;
        end
      end else begin
        o_core_gnt = i_core_vld;
        o_dbg_gnt  = i_dbg_vld;
      end
    end
  end

  // After any grant, the other requester is favoured next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= REQ_CORE;
    end else if (o_core_gnt) begin
      r_rr_ptr <= REQ_DBG;
    end else if (o_dbg_gnt) begin
      r_rr_ptr <= REQ_CORE;
    end
  end

endmodule

// File: rtl/csr_access_controller.sv
// Purpose : sequences core/debug CSR accesses onto the shared CSR bus as read then write.
// Latency : accept->rsp_valid 3 cycles with write, 2 read-only, 1 on a pre-check error.
// Backpressure: ready only in IDLE for the granted requester; responses cannot be stalled.
//
// Ports: core_req_* / core_rsp_* = pipeline CSRRW/CSRRS/CSRRC channel;
//        dbg_req_* / dbg_rsp_*   = debug/management channel (RW write or plain read);
//        csr_* outputs = bus strobes/address/write data from latched request state;
//        csr_read_data/csr_request_output = combinational OR of all registers.
module csr_access_controller
  import csr_access_pkg::*;
#(
  parameter bit READ_ONLY_CHECK = 1'b1,
  parameter bit DEBUG_PRIORITY  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [1:0]  core_req_op,
  input  logic        core_req_no_write,
  input  logic [11:0] core_req_address,
  input  logic [31:0] core_req_data,
  output logic        core_rsp_valid,
  output logic [31:0] core_rsp_data,
  output logic        core_rsp_error,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_req_write,
  input  logic [11:0] dbg_req_address,
  input  logic [31:0] dbg_req_data,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_data,
  output logic        dbg_rsp_error,
  output logic        csr_write_enable,
  output logic        csr_read_enable,
  output logic [11:0] csr_address,
  output logic [31:0] csr_write_data,
  input  logic [31:0] csr_read_data,
  input  logic        csr_request_output
);

  csr_state_e  r_state;
  csr_state_e  w_next_state;

  // Latched request; the bus is driven only from these.
  req_id_e     r_req_id;
  csr_op_e     r_op;
  logic        r_no_write;
  logic [11:0] r_addr;
  logic [31:0] r_operand;
  logic [31:0] r_old;
  logic        r_err;

  logic        w_arb_en;
  logic        w_core_gnt;
  logic        w_dbg_gnt;
  logic        w_accept;
  csr_op_e     w_in_op;
  logic        w_in_no_write;
  logic [11:0] w_in_addr;
  logic [31:0] w_in_data;
  logic        w_in_needs_write;
  logic        w_precheck_err;

  // No accepts while reset is asserted, so nothing is handshaken and then dropped.
  assign w_arb_en = (r_state == ST_IDLE) && !rst;

  csr_request_arbiter #(
    .DEBUG_PRIORITY(DEBUG_PRIORITY)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_arb_en),
    .i_core_vld (core_req_valid),
    .i_dbg_vld  (dbg_req_valid),
    .o_core_gnt (w_core_gnt),
    .o_dbg_gnt  (w_dbg_gnt)
  );

  assign core_req_ready = w_core_gnt;
  assign dbg_req_ready  = w_dbg_gnt;
  assign w_accept       = w_core_gnt | w_dbg_gnt;

  // Debug accesses map onto core ops: a write is RW, a read is RS with no write.
  always_comb begin
    if (w_dbg_gnt) begin
      w_in_op       = dbg_req_write ? CSR_OP_RW : CSR_OP_RS;
      w_in_no_write = ~dbg_req_write;
      w_in_addr     = dbg_req_address;
      w_in_data     = dbg_req_data;
    end else begin
      w_in_op       = csr_op_e'(core_req_op);
      w_in_no_write = core_req_no_write;
      w_in_addr     = core_req_address;
      w_in_data     = core_req_data;
    end
  end

  assign w_in_needs_write = csr_needs_write(w_in_op, w_in_no_write);

  // Rejected before touching the bus: reserved op, or a write to read-only space.
  assign w_precheck_err = (w_in_op == CSR_OP_RSVD) ||
                          (READ_ONLY_CHECK && csr_is_read_only(w_in_addr) && w_in_needs_write);

  assign csr_address = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    csr_read_enable  = 1'b0;
    csr_write_enable = 1'b0;
    csr_write_data   = 32'h0;
    core_rsp_valid   = 1'b0;
    core_rsp_data    = 32'h0;
    core_rsp_error   = 1'b0;
    dbg_rsp_valid    = 1'b0;
    dbg_rsp_data     = 32'h0;
    dbg_rsp_error    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_precheck_err ? ST_RESPOND : ST_READ;
        end
      end
      ST_READ: begin
        csr_read_enable = 1'b1;
        // Nobody claimed the address: report an error and skip the write.
        if (!csr_request_output) begin
          w_next_state = ST_RESPOND;
        end else if (csr_needs_write(r_op, r_no_write)) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_RESPOND;
        end
      end
      ST_WRITE: begin
        csr_write_enable = 1'b1;
        csr_write_data   = csr_modify(r_op, r_old, r_operand);
        w_next_state     = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (r_req_id == REQ_CORE) begin
          core_rsp_valid = 1'b1;
          core_rsp_data  = r_err ? 32'h0 : r_old;
          core_rsp_error = r_err;
        end else begin
          dbg_rsp_valid  = 1'b1;
          dbg_rsp_data   = r_err ? 32'h0 : r_old;
          dbg_rsp_error  = r_err;
        end
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_id   <= REQ_CORE;
      r_op       <= CSR_OP_RSVD;
      r_no_write <= 1'b0;
      r_addr     <= 12'h0;
      r_operand  <= 32'h0;
      r_old      <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_id   <= w_dbg_gnt ? REQ_DBG : REQ_CORE;
            r_op       <= w_in_op;
            r_no_write <= w_in_no_write;
            r_addr     <= w_in_addr;
            r_operand  <= w_in_data;
            r_old      <= 32'h0;
            r_err      <= w_precheck_err;
          end
        end
        ST_READ: begin
          if (csr_request_output) begin
            r_old <= csr_read_data;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_controller.sv
module tb_csr_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid, core_req_ready, core_req_no_write;
  logic [1:0]  core_req_op;
  logic [11:0] core_req_address;
  logic [31:0] core_req_data;
  logic        core_rsp_valid, core_rsp_error;
  logic [31:0] core_rsp_data;
  logic        dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [11:0] dbg_req_address;
  logic [31:0] dbg_req_data;
  logic        dbg_rsp_valid, dbg_rsp_error;
  logic [31:0] dbg_rsp_data;
  logic        csr_write_enable, csr_read_enable, csr_request_output;
  logic [11:0] csr_address;
  logic [31:0] csr_write_data, csr_read_data;

  // Second instance with debug priority; shares request fields and bus inputs.
  logic        p_core_valid, p_dbg_valid;
  logic        p_core_ready, p_dbg_ready;
  logic        p_core_rsp_valid, p_core_rsp_error, p_dbg_rsp_valid, p_dbg_rsp_error;
  logic [31:0] p_core_rsp_data, p_dbg_rsp_data;
  logic        p_wen, p_ren;
  logic [11:0] p_addr;
  logic [31:0] p_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_access_controller #(.READ_ONLY_CHECK(1'b1), .DEBUG_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_op(core_req_op), .core_req_no_write(core_req_no_write),
    .core_req_address(core_req_address), .core_req_data(core_req_data),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_error(core_rsp_error),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_write(dbg_req_write),
    .dbg_req_address(dbg_req_address), .dbg_req_data(dbg_req_data),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_error(dbg_rsp_error),
    .csr_write_enable(csr_write_enable), .csr_read_enable(csr_read_enable),
    .csr_address(csr_address), .csr_write_data(csr_write_data),
    .csr_read_data(csr_read_data), .csr_request_output(csr_request_output)
  );

  csr_access_controller #(.READ_ONLY_CHECK(1'b1), .DEBUG_PRIORITY(1'b1)) dut_p (
    .clk(clk), .rst(rst),
    .core_req_valid(p_core_valid), .core_req_ready(p_core_ready),
    .core_req_op(core_req_op), .core_req_no_write(core_req_no_write),
    .core_req_address(core_req_address), .core_req_data(core_req_data),
    .core_rsp_valid(p_core_rsp_valid), .core_rsp_data(p_core_rsp_data), .core_rsp_error(p_core_rsp_error),
    .dbg_req_valid(p_dbg_valid), .dbg_req_ready(p_dbg_ready), .dbg_req_write(dbg_req_write),
    .dbg_req_address(dbg_req_address), .dbg_req_data(dbg_req_data),
    .dbg_rsp_valid(p_dbg_rsp_valid), .dbg_rsp_data(p_dbg_rsp_data), .dbg_rsp_error(p_dbg_rsp_error),
    .csr_write_enable(p_wen), .csr_read_enable(p_ren),
    .csr_address(p_addr), .csr_write_data(p_wdata),
    .csr_read_data(csr_read_data), .csr_request_output(csr_request_output)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access from core (dbg=0) or debug (dbg=1); for debug, nw=0 means write.
  task automatic txn(input string tag, input bit dbg, input logic [1:0] op, input bit nw,
                     input logic [11:0] addr, input logic [31:0] data,
                     input logic [31:0] rd, input bit claim,
                     input int exp_lat, input int exp_nrd, input int exp_nwr,
                     input logic [31:0] exp_wd, input logic [31:0] exp_rsp, input bit exp_err);
    int lat = 0, nrd = 0, nwr = 0, both = 0, other = 0;
    bit got = 0;
    logic [31:0] wd = 32'h0, rsp = 32'h0;
    logic [11:0] bus_addr = 12'h0;
    logic err = 1'b0;
    csr_read_data      = rd;
    csr_request_output = claim;
    if (dbg) begin
      dbg_req_valid = 1'b1; dbg_req_write = ~nw; dbg_req_address = addr; dbg_req_data = data;
    end else begin
      core_req_valid = 1'b1; core_req_op = op; core_req_no_write = nw;
      core_req_address = addr; core_req_data = data;
    end
    #1;
    chk({tag, ".ready"}, dbg ? dbg_req_ready : core_req_ready, 1);
    tick();
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (!got) begin
        if (csr_read_enable) begin nrd++; bus_addr = csr_address; end
        if (csr_write_enable) begin nwr++; wd = csr_write_data; end
        if (csr_read_enable && csr_write_enable) both++;
        if (dbg ? core_rsp_valid : dbg_rsp_valid) other++;
        if (dbg ? dbg_rsp_valid : core_rsp_valid) begin
          got = 1; lat = c;
          rsp = dbg ? dbg_rsp_data : core_rsp_data;
          err = dbg ? dbg_rsp_error : core_rsp_error;
        end
        tick();
      end
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".read_strobes"}, nrd, exp_nrd);
    chk({tag, ".write_strobes"}, nwr, exp_nwr);
    chk({tag, ".strobe_overlap"}, both, 0);
    chk({tag, ".wrong_rsp"}, other, 0);
    if (exp_nrd != 0) chk({tag, ".bus_addr"}, bus_addr, addr);
    if (exp_nwr != 0) chk({tag, ".wdata"}, wd, exp_wd);
    chk({tag, ".rsp_data"}, rsp, exp_rsp);
    chk({tag, ".rsp_error"}, err, exp_err);
    chk({tag, ".rsp_drop"}, dbg ? dbg_rsp_valid : core_rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    core_req_valid = 1'b0; core_req_op = 2'b00; core_req_no_write = 1'b0;
    core_req_address = 12'h0; core_req_data = 32'h0;
    dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_address = 12'h0; dbg_req_data = 32'h0;
    csr_read_data = 32'h0; csr_request_output = 1'b0;
    p_core_valid = 1'b0; p_dbg_valid = 1'b0;

    // Reset state; ready must stay low even with a valid request during reset.
    tick(); tick();
    core_req_valid = 1'b1;
    #1;
    chk("reset.core_ready", core_req_ready, 0);
    chk("reset.read_en", csr_read_enable, 0);
    chk("reset.write_en", csr_write_enable, 0);
    chk("reset.address", csr_address, 0);
    chk("reset.wdata", csr_write_data, 0);
    chk("reset.rsp", {core_rsp_valid, core_rsp_error, dbg_rsp_valid, dbg_rsp_error}, 0);
    chk("reset.rsp_data", core_rsp_data | dbg_rsp_data, 0);
    core_req_valid = 1'b0;
    rst = 1'b0;
    tick();

    //  tag         dbg op     nw  addr    data          rd            clm lat rd wr wdata         rsp           err
    txn("core_rw",   0, 2'b01, 0, 12'h340, 32'hDEADBEEF, 32'h12345678, 1,  3, 1, 1, 32'hDEADBEEF, 32'h12345678, 0);
    txn("core_rs",   0, 2'b10, 0, 12'h300, 32'h00000008, 32'h00000001, 1,  3, 1, 1, 32'h00000009, 32'h00000001, 0);
    txn("core_rc",   0, 2'b11, 0, 12'h300, 32'h00000001, 32'h00000009, 1,  3, 1, 1, 32'h00000008, 32'h00000009, 0);
    txn("core_rs_nw",0, 2'b10, 1, 12'h300, 32'h00000004, 32'h00000008, 1,  2, 1, 0, 32'h0,        32'h00000008, 0);
    txn("unclaimed", 0, 2'b01, 0, 12'h7C0, 32'h00000055, 32'hFFFFFFFF, 0,  2, 1, 0, 32'h0,        32'h00000000, 1);
    txn("ro_write",  0, 2'b01, 0, 12'hC00, 32'h00000001, 32'h00000077, 1,  1, 0, 0, 32'h0,        32'h00000000, 1);
    txn("ro_read",   0, 2'b10, 1, 12'hC00, 32'h00000000, 32'hABCD0123, 1,  2, 1, 0, 32'h0,        32'hABCD0123, 0);
    txn("rsvd_op",   0, 2'b00, 0, 12'h340, 32'h00000001, 32'h00000077, 1,  1, 0, 0, 32'h0,        32'h00000000, 1);
    txn("dbg_write", 1, 2'b01, 0, 12'h7B0, 32'hCAFEF00D, 32'h00000011, 1,  3, 1, 1, 32'hCAFEF00D, 32'h00000011, 0);
    txn("dbg_read",  1, 2'b10, 1, 12'hC10, 32'h00000000, 32'h00000022, 1,  2, 1, 0, 32'h0,        32'h00000022, 0);
    txn("core_rs2",  0, 2'b10, 0, 12'h300, 32'h000000F0, 32'h0000000F, 1,  3, 1, 1, 32'h000000FF, 32'h0000000F, 0);

    // Round-robin: last grant went to core, so debug wins first, then alternate.
    core_req_op = 2'b10; core_req_no_write = 1'b1; core_req_address = 12'h300;
    dbg_req_write = 1'b0; dbg_req_address = 12'h301;
    csr_read_data = 32'h0; csr_request_output = 1'b1;
    core_req_valid = 1'b1; dbg_req_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("rr%0d.core_ready", g), core_req_ready, (g % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d.dbg_ready", g), dbg_req_ready, (g % 2 == 0) ? 1 : 0);
      tick();
      chk($sformatf("rr%0d.busy_ready", g), {core_req_ready, dbg_req_ready}, 0);
      tick();
      chk($sformatf("rr%0d.rsp", g), {core_rsp_valid, dbg_rsp_valid}, (g % 2 == 1) ? 2 : 1);
      tick();
    end
    core_req_valid = 1'b0; dbg_req_valid = 1'b0;
    tick();

    // Debug priority: core starves while debug keeps requesting.
    p_core_valid = 1'b1; p_dbg_valid = 1'b1;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk($sformatf("prio%0d.core_ready", g), p_core_ready, 0);
      chk($sformatf("prio%0d.dbg_ready", g), p_dbg_ready, 1);
      tick(); tick();
      chk($sformatf("prio%0d.dbg_rsp", g), {p_core_rsp_valid, p_dbg_rsp_valid}, 1);
      tick();
    end
    p_core_valid = 1'b0; p_dbg_valid = 1'b0;
    tick();

    // Reset during a write-bound READ cycle aborts the access.
    core_req_valid = 1'b1; core_req_op = 2'b01; core_req_no_write = 1'b0;
    core_req_address = 12'h340; core_req_data = 32'h00000077;
    csr_read_data = 32'h1; csr_request_output = 1'b1;
    #1;
    chk("abort.ready", core_req_ready, 1);
    tick();
    core_req_valid = 1'b0;
    chk("abort.read_en", csr_read_enable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.no_write", csr_write_enable, 0);
    chk("abort.no_rsp", core_rsp_valid, 0);
    chk("abort.no_read", csr_read_enable, 0);
    txn("after_abort", 0, 2'b10, 1, 12'h300, 32'h0, 32'h00000005, 1, 2, 1, 0, 32'h0, 32'h00000005, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
